wos_stream_ctrl: RTL and testbench

Streaming controller for the weighted order statistics rank datapath. It accepts samples over a valid/ready input and drives the datapath's sample-insert strobe and data. It also owns the window-size configuration `k` and reinitialises the rank registers at every frame start. Filtered results return from the datapath and are buffered in a 2-entry output FIFO behind a valid/ready output, with frame-end marking.

---
 rtl/wos_stream_ctrl.sv | 176 +++++++++++++++++
 tb/tb_wos_stream_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wos_stream_ctrl.sv
// Streaming controller for the weighted order statistics rank datapath:
// frames samples into the datapath and buffers results in a 2-entry FIFO.
module wos_stream_ctrl #(
    parameter int DATA_BITS = 8,
    parameter int N         = 7,
    parameter int K_BITS    = (N - 3) / 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [K_BITS-1:0]    cfg_k,
    input  logic                 cfg_load,
    output logic                 cfg_err,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_last,
    output logic                 dp_rst,
    output logic                 dp_shift,
    output logic [DATA_BITS-1:0] dp_data,
    output logic [K_BITS-1:0]    dp_k,
    input  logic [DATA_BITS-1:0] dp_out,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_last,
    output logic                 busy,
    output logic                 short_frame
);
    localparam int CNT_W = $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_FILL,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t               state;
    logic [K_BITS-1:0]    k_reg;
    logic [CNT_W-1:0]     fill_cnt;
    logic [CNT_W-1:0]     fill_last;
    logic [K_BITS-1:0]    k_inc;
    logic                 cfg_ok;
    logic                 pend;
    logic                 pend_last;
    logic [DATA_BITS-1:0] fifo_data [2];
    logic                 fifo_last [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           fifo_cnt;
    logic [2:0]           occ;
    logic                 accept;
    logic                 push;
    logic                 pop;

    // Fill count value of the last FILL accept: W-2 = 1 + 2*popcount(k_reg).
    always_comb begin
        fill_last = CNT_W'(1);
        for (int i = 0; i < K_BITS; i++) begin
            fill_last = fill_last + (k_reg[i] ? CNT_W'(2) : CNT_W'(0));
        end
    end

    // Thermometer code: adding one to LSB-first contiguous ones clears every set bit.
    always_comb begin
        k_inc  = cfg_k + K_BITS'(1);
        cfg_ok = ((cfg_k & k_inc) == '0);
    end

    assign pop     = m_valid & m_ready;
    assign push    = pend;
    assign occ     = {1'b0, fifo_cnt} + {2'b00, pend} - {2'b00, pop};

    always_comb begin
        s_ready = 1'b0;
        case (state)
            S_FILL:  s_ready = 1'b1;
            S_RUN:   s_ready = (occ < 3'd2);
            default: s_ready = 1'b0;
        endcase
    end

    assign accept   = s_valid & s_ready;
    assign dp_shift = accept;
    assign dp_data  = s_data;
    assign dp_k     = k_reg;
    assign dp_rst   = rst | (state == S_INIT);
    assign m_valid  = (fifo_cnt != 2'd0);
    assign m_data   = fifo_data[rd_ptr];
    assign m_last   = fifo_last[rd_ptr];
    assign busy     = (state != S_IDLE) | (fifo_cnt != 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            k_reg       <= '1;
            fill_cnt    <= '0;
            pend        <= 1'b0;
            pend_last   <= 1'b0;
            cfg_err     <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            cfg_err     <= cfg_load & (~cfg_ok | (state != S_IDLE));
            short_frame <= 1'b0;
            pend        <= 1'b0;
            if (cfg_load && cfg_ok && state == S_IDLE) begin
                k_reg <= cfg_k;
            end
            case (state)
                S_IDLE: begin
                    if (s_valid && !cfg_load) begin
                        state <= S_INIT;
                    end
                end
                S_INIT: begin
                    fill_cnt <= '0;
                    state    <= S_FILL;
                end
                S_FILL: begin
                    if (accept) begin
                        fill_cnt <= fill_cnt + CNT_W'(1);
                        if (s_last) begin
                            state       <= S_FLUSH;
                            short_frame <= 1'b1;
                        end else if (fill_cnt == fill_last) begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        pend      <= 1'b1;
                        pend_last <= s_last;
                        if (s_last) begin
                            state <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (!pend && fifo_cnt == 2'd0) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Result FIFO: the datapath output is captured the cycle after its shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= dp_out;
                fifo_last[wr_ptr] <= pend_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_wos_stream_ctrl.sv
// Directed bench for wos_stream_ctrl; a stand-in datapath returns the last
// shifted sample plus one, so each result identifies its source sample.
module tb_wos_stream_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] cfg_k = 2'b00;
    logic       cfg_load = 1'b0;
    logic       cfg_err;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'd0;
    logic       s_last = 1'b0;
    logic       dp_rst;
    logic       dp_shift;
    logic [7:0] dp_data;
    logic [1:0] dp_k;
    logic [7:0] dp_out = 8'd0;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] m_data;
    logic       m_last;
    logic       busy;
    logic       short_frame;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    int         acc_cyc[$];
    int         first_mv, rst_cyc, first_shift, short_cnt, err_cnt;
    int         blocked, stall_acc, unstable;
    logic [7:0] frame_a[8];
    logic [7:0] frame_b[8];

    wos_stream_ctrl #(.DATA_BITS(8), .N(7), .K_BITS(2)) dut (
        .clk(clk), .rst(rst), .cfg_k(cfg_k), .cfg_load(cfg_load), .cfg_err(cfg_err),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .dp_rst(dp_rst), .dp_shift(dp_shift), .dp_data(dp_data), .dp_k(dp_k),
        .dp_out(dp_out), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .busy(busy), .short_frame(short_frame)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (dp_shift) dp_out <= dp_data + 8'd1;

    // Drives one frame, observing at each falling edge. Stall holds m_ready low
    // for stall_len cycles once stall_at samples are in; cfg_at pulses cfg_load.
    task automatic run_frame(input logic [7:0] d[8], input int n, input int stall_at,
                             input int stall_len, input int cfg_at, input logic [1:0] cfg_val);
        int         idx = 0;
        int         budget = 0;
        int         stall_left = stall_len;
        logic       cfg_done = 1'b0;
        logic       prev_hold = 1'b0;
        logic [8:0] prev_m = '0;
        got_q.delete();
        acc_cyc.delete();
        first_mv = -1; rst_cyc = -1; first_shift = -1;
        short_cnt = 0; err_cnt = 0; blocked = 0; stall_acc = 0; unstable = 0;
        while (idx < n || busy) begin
            @(posedge clk); #1;
            s_valid  = (idx < n);
            s_data   = (idx < n) ? d[idx] : 8'd0;
            s_last   = (idx == n - 1);
            m_ready  = 1'b1;
            if (stall_at >= 0 && idx >= stall_at && stall_left > 0) begin
                m_ready = 1'b0;
                stall_left--;
            end
            cfg_load = (cfg_at >= 0 && idx == cfg_at && !cfg_done);
            if (cfg_load) begin
                cfg_k    = cfg_val;
                cfg_done = 1'b1;
            end
            @(negedge clk);
            if (dp_rst && first_shift < 0) rst_cyc = cyc;
            if (dp_shift && first_shift < 0) first_shift = cyc;
            if (cfg_err) err_cnt++;
            if (short_frame) short_cnt++;
            if (prev_hold && (!m_valid || {m_last, m_data} !== prev_m)) unstable++;
            prev_hold = m_valid && !m_ready;
            prev_m    = {m_last, m_data};
            if (m_valid && first_mv < 0) first_mv = cyc;
            if (m_valid && m_ready) got_q.push_back({m_last, m_data});
            if (!m_ready && s_valid && !s_ready) blocked++;
            if (!m_ready && s_valid && s_ready) stall_acc++;
            if (s_valid && s_ready) begin
                acc_cyc.push_back(cyc);
                idx++;
            end
            budget++;
            if (budget > 400) begin
                tests_run++; tests_failed++;
                $display("FAIL frame_timeout: got idx=%0d busy=%0b, expected drain within 400 cycles", idx, busy);
                break;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1; cfg_load = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] v);
        @(posedge clk); #1;
        cfg_load = 1'b1; cfg_k = v;
        @(posedge clk); #1;
        cfg_load = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [19:0] exp_v;
        exp_v = {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11};
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if ({s_ready, m_valid, m_data, m_last, dp_shift, cfg_err, short_frame, busy, dp_rst, dp_k} !== exp_v) begin
                tests_failed++;
                $display("FAIL reset_outputs: got %h expected %h",
                         {s_ready, m_valid, m_data, m_last, dp_shift, cfg_err, short_frame, busy, dp_rst, dp_k}, exp_v);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({busy, dp_rst} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_release: got busy/dp_rst=%b expected 00", {busy, dp_rst});
        end
    endtask

    task automatic test_cfg_idle();
        cfg_write(2'b10);
        tests_run++;
        if ({cfg_err, dp_k} !== 3'b1_11) begin
            tests_failed++;
            $display("FAIL cfg_bad_code: got err/k=%b expected 111", {cfg_err, dp_k});
        end
        @(negedge clk);
        tests_run++;
        if (cfg_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL cfg_err_pulse: got %b expected 0", cfg_err);
        end
        cfg_write(2'b01);
        tests_run++;
        if ({cfg_err, dp_k} !== 3'b0_01) begin
            tests_failed++;
            $display("FAIL cfg_load_ok: got err/k=%b expected 001", {cfg_err, dp_k});
        end
    endtask

    task automatic test_frame();
        exp_q = '{{1'b0, 8'd31}, {1'b0, 8'd61}, {1'b0, 8'd71}, {1'b1, 8'd81}};
        run_frame(frame_a, 8, -1, 0, -1, 2'b00);
        tests_run++;
        if (rst_cyc !== first_shift - 1) begin
            tests_failed++;
            $display("FAIL frame_init_before_shift: got dp_rst cycle %0d expected %0d", rst_cyc, first_shift - 1);
        end
        tests_run++;
        if (got_q.size() !== 4) begin
            tests_failed++;
            $display("FAIL frame_result_count: got %0d expected 4", got_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL frame_result_%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (acc_cyc.size() != 8 || first_mv !== acc_cyc[4] + 2) begin
            tests_failed++;
            $display("FAIL frame_latency: got first m_valid cycle %0d expected 5th accept + 2", first_mv);
        end
        tests_run++;
        if (acc_cyc.size() != 8 || acc_cyc[7] - acc_cyc[0] !== 7) begin
            tests_failed++;
            $display("FAIL frame_back_to_back: got %0d accepts, not on 8 consecutive cycles", acc_cyc.size());
        end
        tests_run++;
        if ({short_cnt, err_cnt} !== {32'd0, 32'd0}) begin
            tests_failed++;
            $display("FAIL frame_spurious_pulses: got short=%0d err=%0d expected 0 0", short_cnt, err_cnt);
        end
    endtask

    task automatic test_backpressure();
        exp_q = '{{1'b0, 8'd31}, {1'b0, 8'd61}, {1'b0, 8'd71}, {1'b1, 8'd81}};
        run_frame(frame_a, 8, 5, 10, -1, 2'b00);
        tests_run++;
        if (got_q != exp_q) begin
            tests_failed++;
            $display("FAIL bp_results: got %0d results (first %h) expected 4 starting %h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 9'h0, exp_q[0]);
        end
        tests_run++;
        if (stall_acc !== 1 || blocked == 0) begin
            tests_failed++;
            $display("FAIL bp_s_ready_drop: got %0d accepts under stall, %0d blocked cycles, expected 1 and >0", stall_acc, blocked);
        end
        tests_run++;
        if (unstable !== 0) begin
            tests_failed++;
            $display("FAIL bp_output_stable: got %0d changes while stalled expected 0", unstable);
        end
    endtask

    task automatic test_cfg_in_run();
        run_frame(frame_a, 8, -1, 0, 5, 2'b00);
        tests_run++;
        if ({err_cnt, dp_k} !== {32'd1, 2'b01}) begin
            tests_failed++;
            $display("FAIL cfg_in_run: got err pulses=%0d k=%b expected 1 01", err_cnt, dp_k);
        end
        tests_run++;
        if (got_q.size() !== 4) begin
            tests_failed++;
            $display("FAIL cfg_in_run_count: got %0d expected 4", got_q.size());
        end
    endtask

    task automatic test_short_frame();
        cfg_write(2'b11);
        run_frame(frame_a, 4, -1, 0, -1, 2'b00);
        tests_run++;
        if ({first_mv, short_cnt} !== {-32'sd1, 32'd1}) begin
            tests_failed++;
            $display("FAIL short_frame: got first_mv=%0d pulses=%0d expected -1 1", first_mv, short_cnt);
        end
        @(negedge clk);
        tests_run++;
        if ({busy, s_ready, m_valid} !== 3'b000) begin
            tests_failed++;
            $display("FAIL short_frame_idle: got busy/s_ready/m_valid=%b expected 000", {busy, s_ready, m_valid});
        end
    endtask

    task automatic test_min_window();
        cfg_write(2'b00);
        run_frame(frame_b, 3, -1, 0, -1, 2'b00);
        tests_run++;
        if (got_q.size() !== 1 || got_q[0] !== {1'b1, 8'd8}) begin
            tests_failed++;
            $display("FAIL min_window: got %0d results (first %h) expected 1 of 108",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 9'h0);
        end
    endtask

    task automatic test_reset_mid_run();
        int idx = 0;
        cfg_write(2'b01);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            s_valid = 1'b1; s_data = frame_a[idx]; s_last = 1'b0; m_ready = 1'b0;
            @(negedge clk);
            if (s_valid && s_ready) idx++;
            if (idx >= 6 && !s_ready) break;
        end
        @(posedge clk); #1;
        tests_run++;
        if (m_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_run_fifo_full: got m_valid=%b expected 1", m_valid);
        end
        rst = 1'b1; s_valid = 1'b0;
        #1;
        tests_run++;
        if ({m_valid, busy, s_ready, dp_rst, dp_k} !== 6'b0_0_0_1_11) begin
            tests_failed++;
            $display("FAIL mid_run_reset: got %b expected 000111", {m_valid, busy, s_ready, dp_rst, dp_k});
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({busy, m_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL mid_run_release: got busy/m_valid=%b expected 00", {busy, m_valid});
        end
        exp_q = '{{1'b0, 8'd71}, {1'b1, 8'd81}};
        run_frame(frame_a, 8, -1, 0, -1, 2'b00);
        tests_run++;
        if (got_q != exp_q || rst_cyc !== first_shift - 1) begin
            tests_failed++;
            $display("FAIL mid_run_next_frame: got %0d results, init cycle %0d, expected 2 results and init %0d",
                     got_q.size(), rst_cyc, first_shift - 1);
        end
    endtask

    initial begin
        frame_a = '{8'd10, 8'd50, 8'd20, 8'd40, 8'd30, 8'd60, 8'd70, 8'd80};
        frame_b = '{8'd5, 8'd6, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        test_reset();
        test_cfg_idle();
        test_frame();
        test_backpressure();
        test_cfg_in_run();
        test_short_frame();
        test_min_window();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
